// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned STREAK_W  = 2;
  localparam logic [STREAK_W-1:0] STREAK_MAX = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory,
// favouring data but granting a fetch after two data wins while it waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / BYTE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [BE_W-1:0]   m_be,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall
);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                sel_d_q, sel_d_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, grant decision, payload latch and response capture
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    sel_d_d   = sel_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    m_req_d   = 1'b0;
    m_we_d    = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || (streak_q != STREAK_MAX))) begin
          state_d = SERVE_D;
          sel_d_d = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_be;
          m_req_d = 1'b1;
          m_we_d  = d_we;
          // A waiting fetch here implies streak is below its ceiling
          if (i_req) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (i_req) begin
          state_d  = SERVE_I;
          sel_d_d  = 1'b0;
          we_d     = 1'b0;
          addr_d   = i_addr;
          wdata_d  = '0;
          be_d     = '0;
          m_req_d  = 1'b1;
          streak_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (m_ready) begin
          state_d = RESP;
          i_ack_d = ~sel_d_q;
          d_ack_d = sel_d_q;
          if (!sel_d_q) begin
            i_rdata_d = m_rdata;
          end else if (!we_q) begin
            d_rdata_d = m_rdata;
          end
        end else begin
          m_req_d = 1'b1;
          m_we_d  = we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q  <= '0;
      sel_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      streak_q  <= streak_d;
      sel_d_q   <= sel_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_be    = be_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall   = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: fetch, load, store, fairness, reset.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic          i_ack, d_ack, m_req, m_we, stall;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .stall(stall)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  exp_t          sb[$];
  logic [DW-1:0] last_i, last_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    #1;
    check(tag, 64'(stall), 64'(exp));
  endtask

  // Called in an IDLE cycle with requests driven; returns in the IDLE cycle after RESP
  task automatic do_access(input int delay, input logic [DW-1:0] rdata, input bit scramble);
    exp_t e;
    int   k;
    k = 0;
    do begin
      step();
      k++;
    end while (!m_req && k < 4);
    check("grant_latency", 64'(k), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("m_req_serve", 64'(m_req), 64'd1);
    check("m_addr", 64'(m_addr), 64'(e.addr));
    check("m_we", 64'(m_we), 64'(e.we));
    if (e.is_d) begin
      check("m_wdata", 64'(m_wdata), 64'(e.wdata));
      check("m_be", 64'(m_be), 64'(e.be));
    end
    if (scramble) begin
      i_req   = 1'b0;
      d_req   = 1'b0;
      i_addr  = ~i_addr;
      d_addr  = ~d_addr;
      d_wdata = ~d_wdata;
      d_be    = ~d_be;
      d_we    = ~d_we;
    end
    check_stall("stall_serve", i_req | d_req);
    for (int c = 0; c < delay; c++) begin
      m_ready = 1'b0;
      step();
      check("hold_m_req", 64'(m_req), 64'd1);
      check("hold_m_addr", 64'(m_addr), 64'(e.addr));
      check("hold_m_we", 64'(m_we), 64'(e.we));
      if (e.is_d) begin
        check("hold_m_wdata", 64'(m_wdata), 64'(e.wdata));
        check("hold_m_be", 64'(m_be), 64'(e.be));
      end
      check("no_early_ack", 64'({i_ack, d_ack}), 64'd0);
    end
    m_rdata = rdata;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    m_rdata = $urandom;
    if (e.is_d) begin
      if (!e.we) last_d = rdata;
    end else begin
      last_i = rdata;
    end
    check("i_ack", 64'(i_ack), 64'(!e.is_d));
    check("d_ack", 64'(d_ack), 64'(e.is_d));
    check("m_req_resp", 64'(m_req), 64'd0);
    check("i_rdata", 64'(i_rdata), 64'(last_i));
    check("d_rdata", 64'(d_rdata), 64'(last_d));
    check_stall("stall_resp", (i_req & e.is_d) | (d_req & !e.is_d));
    step();
    check("ack_one_cycle", 64'({i_ack, d_ack}), 64'd0);
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
    last_i = '0; last_d = '0;
    repeat (2) step();
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_we", 64'(m_we), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_wdata", 64'(m_wdata), 64'd0);
    check("rst_m_be", 64'(m_be), 64'd0);
    check("rst_acks", 64'({i_ack, d_ack}), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    rst = 1'b0;
    step();

    // Single fetch, ready in first serve cycle
    i_req = 1'b1; i_addr = 32'h0000_0100;
    sb.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h100, wdata: '0, be: '0});
    do_access(0, 32'h00A0_0093, 1'b1);

    // Stray m_ready while idle
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("idle_ready_acks", 64'({i_ack, d_ack}), 64'd0);
    check("idle_ready_m_req", 64'(m_req), 64'd0);
    check_stall("idle_ready_stall", 1'b0);
    step();
    check("idle_ready_acks2", 64'({i_ack, d_ack}), 64'd0);
    check("idle_ready_m_req2", 64'(m_req), 64'd0);

    // Load to give d_rdata a known non-zero value
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1000; d_wdata = '0; d_be = '0;
    sb.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h1000, wdata: '0, be: '0});
    do_access(1, 32'h1234_5678, 1'b1);

    // Store with three wait cycles; d_rdata must keep the load value
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    sb.push_back('{is_d: 1'b1, we: 1'b1, addr: 32'h2000, wdata: 32'hDEAD_BEEF, be: 4'b0011});
    do_access(3, 32'hCAFE_F00D, 1'b1);

    // Both ports held: expect D, D, I, D, D, I
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h0000_0400; d_addr = 32'h0000_0800; d_wdata = '0; d_be = '0;
    for (int g = 0; g < 6; g++) begin
      if (g % 3 == 2) sb.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h400, wdata: '0, be: '0});
      else            sb.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h800, wdata: '0, be: '0});
    end
    for (int g = 0; g < 6; g++) begin
      do_access(g % 2, 32'h0000_5000 + 32'(g), 1'b0);
    end
    i_req = 1'b0; d_req = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of a data access
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
    step();
    check("abort_m_req", 64'(m_req), 64'd1);
    check("abort_m_addr", 64'(m_addr), 64'h3000);
    step();
    #1 rst = 1'b1;
    #1;
    check("abort_rst_m_req", 64'(m_req), 64'd0);
    check("abort_rst_m_addr", 64'(m_addr), 64'd0);
    check("abort_rst_d_ack", 64'(d_ack), 64'd0);
    check("abort_rst_d_rdata", 64'(d_rdata), 64'd0);
    check("abort_rst_i_rdata", 64'(i_rdata), 64'd0);
    last_i = '0; last_d = '0;
    d_req = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("abort_no_ack", 64'({i_ack, d_ack}), 64'd0);
      check("abort_idle_m_req", 64'(m_req), 64'd0);
    end

    // Arbiter returns to normal service after reset
    i_req = 1'b1; i_addr = 32'h0000_0104;
    sb.push_back('{is_d: 1'b0, we: 1'b0, addr: 32'h104, wdata: '0, be: '0});
    do_access(1, 32'h0040_006F, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_req  in  1  instruction-fetch request (level).
REQ-006 SHALL have port i_addr  in  ADDR_W  fetch address.
REQ-007 SHALL have port i_rdata  out  DATA_W  fetched word.
REQ-008 SHALL have port i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  in  1  data-access request (level).
REQ-010 SHALL have port d_we  in  1  data write enable (1 = store).
REQ-011 SHALL have port d_addr  in  ADDR_W  data address.
REQ-012 SHALL have port d_wdata  in  DATA_W  store data.
REQ-013 SHALL have port d_be  in  DATA_W/8  store byte enables.
REQ-014 SHALL have port d_rdata  out  DATA_W  load data.
REQ-015 SHALL have port d_ack  out  1  one-cycle data completion pulse.
REQ-016 SHALL have ports m_req, m_we (out 1), m_addr (out ADDR_W), m_wdata (out DATA_W), m_be (out DATA_W/8) driving the shared single-port memory.
REQ-017 SHALL have ports m_rdata  in  DATA_W and m_ready  in  1  memory read data and completion.
REQ-018 SHALL have port stall  out  1  pipeline stall, equal to (i_req & ~i_ack) | (d_req & ~d_ack).

Function
REQ-019 SHALL implement an FSM with states IDLE, SERVE_I, SERVE_D, RESP.
REQ-020 SHALL sample i_req/d_req only in IDLE; requests in other states are ignored until IDLE returns.
REQ-021 IDLE: d_req only -> SERVE_D; i_req only -> SERVE_I; neither -> stay IDLE.
REQ-022 IDLE with both requests SHALL grant data unless streak == 2, in which case it grants instruction.
REQ-023 streak (2-bit, saturating at 2) SHALL increment on each data grant made while i_req = 1, and clear on any instruction grant.
REQ-024 The granted address, write data, byte enables and d_we SHALL be registered at grant and held on m_* throughout SERVE_x, independent of later requester input changes.
REQ-025 m_req SHALL be 1 exactly in SERVE_I/SERVE_D; m_we SHALL be 0 in SERVE_I and the latched d_we in SERVE_D.
REQ-026 SERVE_x SHALL remain until m_ready = 1 (unbounded wait), then go to RESP; m_ready outside SERVE_x SHALL be ignored.
REQ-027 On the m_ready cycle of a read, m_rdata SHALL be captured into i_rdata (SERVE_I) or d_rdata (SERVE_D); stores SHALL leave d_rdata unchanged.
REQ-028 RESP SHALL assert exactly one of i_ack/d_ack for one cycle, then return to IDLE unconditionally.
REQ-029 i_rdata/d_rdata SHALL hold their value until the next capture.
REQ-030 Minimum latency: request seen in IDLE at cycle N, m_ready in cycle N+1 -> ack in cycle N+2; back-to-back accesses occupy 3 cycles each.

Reset
REQ-031 rst = 1 SHALL immediately force state IDLE, streak 0, all m_* outputs 0, i_ack = d_ack = 0, i_rdata = d_rdata = 0, including mid-SERVE; the in-flight access is abandoned without ack.

Structure
REQ-032 The state enum and the byte-enable width constant SHALL live in shared package mem_arb_pkg.
REQ-033 No sub-module is needed; FSM, streak counter and capture registers reside in mem_arbiter.

Verification
REQ-034 i_req=1, i_addr=0x100, m_ready=1 in first SERVE cycle, m_rdata=0x00A00093 -> i_ack at N+2, i_rdata=0x00A00093, m_we=0.
REQ-035 d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> m_we=1 with those values held for 3 stall cycles of m_ready=0; d_ack on the cycle after m_ready; d_rdata unchanged.
REQ-036 i_req and d_req held continuously -> grant order D, D, I, D, D, I; streak clears after each I grant.
REQ-037 rst asserted during SERVE_D with m_ready=0 -> m_req=0 immediately, no d_ack, IDLE after release.
REQ-038 m_ready pulsed while IDLE with no request -> no ack, no state change; stall tracks REQ-018 throughout.
